spi_seg_frame_rx: RTL and testbench
===================================

Name: spi_seg_frame_rx

Overview:
SPI mode-0 slave front end feeding the segment controller. Oversamples SCK/CS_N/MOSI in the system clock domain and assembles 16-bit frames. Write frames update a bank of four 8-bit display registers; read frames return a register on MISO. Presents the bank as a packed bus to the downstream segment drive logic.

Parameters:
SYNC_STAGES, 2, synchroniser depth on sck/cs_n/mosi (minimum 2).
NUM_REGS, 4, display registers; addresses 0..NUM_REGS-1 valid.
RESET_VAL, 8'h00, reset value of every display register.

Ports:
clk  input  1  system clock; must be at least 4x SCK frequency.
rst  input  1  asynchronous, active-high reset.
spi_sck  input  1  SPI clock from master, idle low.
spi_cs_n  input  1  chip select, active low.
spi_mosi  input  1  master-out data, MSB first.
spi_miso  output  1  slave-out data; driven low when not selected.
disp_regs  output  8*NUM_REGS  packed registers, reg0 in [7:0].
wr_strobe  output  1  one-clk pulse on each committed write.
wr_addr  output  4  address of last committed write.
frame_err  output  1  sticky: a frame was aborted or addressed out of range; cleared by a valid write to addr 4'hF.
frame_cnt  output  8  count of committed writes, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): disp_regs all RESET_VAL; spi_miso=0; wr_strobe=0; wr_addr=0; frame_err=0; frame_cnt=0; bit counter=0; state IDLE.
- All three SPI inputs pass through SYNC_STAGES flops, plus one history flop for edge detection. Rise/fall of sck is detected from the last synchronised stage and its history flop. Input-to-action latency is SYNC_STAGES+1 clk.
- Frame format, MSB first: bit15 = W (1 write, 0 read); bits14:12 reserved, ignored; bits11:8 = addr; bits7:0 = data.
- FSM states:
  - IDLE: waits for cs_n low -> SHIFT with bit counter 0.
  - SHIFT: samples mosi on each sck rise; counter increments.
    - At 8 rises, the header is latched.
    - Read with addr < NUM_REGS: on the next sck fall, the shift-out register loads reg[addr] and MISO presents bit7. Each later fall shifts the next bit.
    - Read with addr >= NUM_REGS: MISO sends 8'h00 and frame_err is set.
    - 16th rise -> COMMIT.
  - COMMIT: one clk.
    - Write, addr < NUM_REGS: update reg[addr]; pulse wr_strobe; set wr_addr; frame_cnt+1.
    - Write, addr = 4'hF: clear frame_err; no register change; no strobe.
    - Other out-of-range write: set frame_err; nothing else.
    - Read: no register or counter change.
    - Then -> DONE.
  - DONE: ignores further sck edges (bits beyond 16 are discarded) until cs_n high -> IDLE.
- cs_n high in SHIFT (fewer than 16 rises): frame aborted, no register change, frame_err set, -> IDLE.
- cs_n high always forces spi_miso=0 within SYNC_STAGES+1 clk.
- During header bits of any frame, MISO outputs 0.
- disp_regs change only in COMMIT; the downstream stage sees new data on the clk after wr_strobe's rising edge (same edge registered).
- Reset asserted mid-frame: immediate return to reset values. The remainder of the frame is ignored until cs_n is seen high, then low again.
- Simultaneous sck edge and cs_n rise in the same synchronised cycle: cs_n wins; the edge is ignored.

Decomposition:
- Shared package spi_seg_pkg: FRAME_BITS=16, HDR_BITS=8, ADDR_CLEAR=4'hF, state enum {IDLE, SHIFT, COMMIT, DONE}.
- One sub-module, spi_seg_sync: a parameterised SYNC_STAGES-deep synchroniser with an edge-detect output, instantiated for sck and cs_n. MOSI uses the plain synchroniser path from the same module.

Test Plan:
- Write frame 16'h8_1A5 (W=1, addr 1, data A5) at SCK = clk/8 -> disp_regs[15:8]=8'hA5; wr_strobe exactly 1 clk; wr_addr=1; frame_cnt=1.
- After writing reg2=8'h3C, send read frame 16'h0200 -> MISO bits on rises 9..16 read 0,0,1,1,1,1,0,0; disp_regs unchanged; frame_cnt unchanged.
- Write frame with cs_n raised after 10 bits -> no register change; frame_err=1. Then write 16'h8F00 -> frame_err=0, no strobe.
- Write 16'h8_5FF (addr 5, out of range) -> frame_err=1; disp_regs unchanged; no strobe.
- 24-bit burst 16'h8_077 followed by 8'hFF -> reg0=8'h77 only; extra byte ignored; one strobe.
- 256 valid writes -> frame_cnt wraps to 0. Assert rst mid-frame -> all outputs reach their reset values immediately, and the next full frame is accepted normally.

Source files
------------

// File: rtl/spi_seg_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI segment-register front end.
package spi_seg_pkg;

    localparam int         FRAME_BITS = 16;
    localparam int         HDR_BITS   = 8;
    localparam logic [3:0] ADDR_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        DONE
    } state_e;

endpackage

// File: rtl/spi_seg_sync.sv
// STAGES-deep synchroniser for one asynchronous input, followed by a history flop
// so that rising/falling edges of the synchronised level can be detected.
module spi_seg_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_seg_frame_rx.sv
// SPI mode-0 slave: assembles 16-bit frames (W, addr, data) into a bank of display
// registers and answers read frames on MISO; all SPI pins are oversampled in clk.
module spi_seg_frame_rx
    import spi_seg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [8*NUM_REGS-1:0] disp_regs,
    output logic                  wr_strobe,
    output logic [3:0]            wr_addr,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt
);

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
    localparam logic [4:0] HDR_LAST   = 5'(HDR_BITS - 1);
    localparam logic [4:0] HDR_CNT    = 5'(HDR_BITS);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

    logic sck_rise, sck_fall, sck_level_unused;
    logic csn_s, csn_fall, csn_rise_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    state_e                state_q;
    logic [4:0]            bit_cnt_q;
    logic [7:0]            shift_q, shift_d;
    logic                  hdr_w_q;
    logic [3:0]            hdr_addr_q;
    logic [7:0]            out_q, rd_data_d;
    logic                  addr_ok_d;
    logic                  miso_q;
    logic [8*NUM_REGS-1:0] regs_q;
    logic                  wr_strobe_q;
    logic [3:0]            wr_addr_q;
    logic                  frame_err_q;
    logic [7:0]            frame_cnt_q;

    // cs_n resets to "selected" so a frame already in flight at reset release never
    // produces a falling edge; a new frame needs a real high-then-low on the pin.
    spi_seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d_i(spi_sck),
        .q_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csn (
        .clk(clk), .rst(rst), .d_i(spi_cs_n),
        .q_o(csn_s), .rise_o(csn_rise_unused), .fall_o(csn_fall)
    );

    spi_seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    always_comb begin
        shift_d   = {shift_q[6:0], mosi_s};
        addr_ok_d = ({1'b0, hdr_addr_q} < NUM_REGS_W);
        rd_data_d = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok_d && hdr_addr_q == 4'(i)) begin
                rd_data_d = regs_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hdr_w_q     <= 1'b0;
            hdr_addr_q  <= '0;
            out_q       <= '0;
            miso_q      <= 1'b0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (csn_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // cs_n is checked first so a coincident sck edge is dropped.
                    if (csn_s) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (sck_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == HDR_LAST) begin
                            hdr_w_q    <= shift_d[7];
                            hdr_addr_q <= shift_d[3:0];
                        end
                        if (bit_cnt_q == FRAME_LAST) begin
                            state_q <= COMMIT;
                        end
                    end else if (sck_fall && !hdr_w_q && bit_cnt_q >= HDR_CNT) begin
                        // First fall after the header loads the reply; later falls shift it.
                        if (bit_cnt_q == HDR_CNT) begin
                            out_q  <= rd_data_d;
                            miso_q <= rd_data_d[7];
                            if (!addr_ok_d) begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            out_q  <= {out_q[6:0], 1'b0};
                            miso_q <= out_q[6];
                        end
                    end
                end
                COMMIT: begin
                    if (hdr_w_q) begin
                        if (addr_ok_d) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (hdr_addr_q == 4'(i)) begin
                                    regs_q[8*i +: 8] <= shift_q;
                                end
                            end
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= hdr_addr_q;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else if (hdr_addr_q == ADDR_CLEAR) begin
                            frame_err_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (csn_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (csn_s) begin
                miso_q <= 1'b0;
            end
        end
    end

    assign spi_miso  = miso_q;
    assign disp_regs = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_seg_frame_rx.sv
// Randomised self-checking bench for spi_seg_frame_rx, driving SPI frames at clk/8
// and comparing against a frame-level reference model of the register bank.
module tb_spi_seg_frame_rx;

    localparam int NUM_REGS = 4;
    localparam int HALF     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, csn, mosi, miso;
    logic [31:0] dispRegs;
    logic        wrStrobe;
    logic [3:0]  wrAddr;
    logic        frameErr;
    logic [7:0]  frameCnt;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: register contents and status as seen at the frame level.
    logic [7:0] modelRegs [NUM_REGS];
    logic [7:0] modelCnt;
    logic       modelErr;
    logic [3:0] modelAddr;
    int         modelStrobes = 0;

    // Strobe monitor: counts pulses and the longest run of consecutive high cycles.
    int strobeCount  = 0;
    int strobeRun    = 0;
    int strobeMaxRun = 0;

    logic [15:0] misoBits;

    spi_seg_frame_rx #(.SYNC_STAGES(2), .NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (sck),
        .spi_cs_n  (csn),
        .spi_mosi  (mosi),
        .spi_miso  (miso),
        .disp_regs (dispRegs),
        .wr_strobe (wrStrobe),
        .wr_addr   (wrAddr),
        .frame_err (frameErr),
        .frame_cnt (frameCnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrStrobe) begin
            strobeRun = strobeRun + 1;
            if (strobeRun == 1) strobeCount = strobeCount + 1;
            if (strobeRun > strobeMaxRun) strobeMaxRun = strobeRun;
        end else begin
            strobeRun = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clkWait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 8'h00;
        modelCnt  = 8'h00;
        modelErr  = 1'b0;
        modelAddr = 4'h0;
    endtask

    // One SPI bit, mode 0: MOSI set while SCK low, MISO sampled just before the rise.
    task automatic sendBit(input logic b, input int idx);
        mosi = b;
        clkWait(HALF);
        if (idx < 16) misoBits[15-idx] = miso;
        sck = 1'b1;
        clkWait(HALF);
        sck = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int totalBits, input int sentBits);
        misoBits = 16'h0000;
        csn = 1'b0;
        clkWait(HALF);
        for (int i = 0; i < sentBits; i++) sendBit(word[totalBits-1-i], i);
        clkWait(HALF);
        csn  = 1'b1;
        mosi = 1'b0;
        clkWait(3 * HALF);
    endtask

    task automatic checkState(input string tag);
        logic [31:0] expDisp;
        for (int i = 0; i < NUM_REGS; i++) expDisp[8*i +: 8] = modelRegs[i];
        checkOutput({tag, "_regs"}, dispRegs, expDisp);
        checkOutput({tag, "_cnt"}, frameCnt, modelCnt);
        checkOutput({tag, "_err"}, frameErr, modelErr);
        checkOutput({tag, "_addr"}, wrAddr, modelAddr);
        checkOutput({tag, "_strobes"}, strobeCount, modelStrobes);
        checkOutput({tag, "_strobe_width"}, strobeMaxRun, (modelStrobes > 0) ? 1 : 0);
    endtask

    task automatic runFrame(input string tag, input logic [31:0] word, input int totalBits, input int sentBits);
        logic [31:0] head;
        logic [15:0] frame;
        logic [7:0]  readData;
        int          a;
        head     = word >> (totalBits - 16);
        frame    = head[15:0];
        readData = 8'h00;
        a        = int'(frame[11:8]);
        applyStimulus(word, totalBits, sentBits);
        if (sentBits < 16) begin
            modelErr = 1'b1;
        end else if (frame[15]) begin
            if (a < NUM_REGS) begin
                modelRegs[a] = frame[7:0];
                modelCnt     = modelCnt + 8'd1;
                modelAddr    = frame[11:8];
                modelStrobes++;
            end else if (frame[11:8] == 4'hF) begin
                modelErr = 1'b0;
            end else begin
                modelErr = 1'b1;
            end
        end else begin
            if (a < NUM_REGS) readData = modelRegs[a];
            else modelErr = 1'b1;
        end
        checkState(tag);
        if (sentBits >= 16) checkOutput({tag, "_miso_bits"}, misoBits, frame[15] ? 16'h0000 : {8'h00, readData});
        checkOutput({tag, "_miso_idle"}, miso, 0);
    endtask

    task automatic randomFrame(input string tag, input logic forceWrite, input logic fullOnly);
        int          r, s;
        logic [3:0]  addr;
        logic [15:0] frame;
        r = $urandom_range(0, 9);
        if (r < 7)       addr = 4'(r % 4);
        else if (r == 7) addr = 4'h4;
        else if (r == 8) addr = 4'(5 + $urandom_range(0, 9));
        else             addr = 4'hF;
        if (forceWrite) addr = 4'($urandom_range(0, NUM_REGS - 1));
        frame = {(forceWrite ? 1'b1 : 1'($urandom_range(0, 1))), 3'($urandom_range(0, 7)), addr, 8'($urandom_range(0, 255))};
        s = fullOnly ? 5 : $urandom_range(0, 9);
        if (s == 0)      runFrame(tag, {16'h0000, frame}, 16, $urandom_range(1, 15));
        else if (s == 1) runFrame(tag, {8'h00, frame, 8'($urandom_range(0, 255))}, 24, 24);
        else             runFrame(tag, {16'h0000, frame}, 16, 16);
    endtask

    initial begin
        rst  = 1'b1;
        sck  = 1'b0;
        csn  = 1'b1;
        mosi = 1'b0;
        modelReset();
        #1;
        checkState("reset");
        checkOutput("reset_miso", miso, 0);
        checkOutput("reset_strobe", wrStrobe, 0);
        clkWait(3);
        rst = 1'b0;
        clkWait(4 * HALF);

        $display("[TB] directed frames");
        runFrame("wr_a5", 32'h81A5, 16, 16);
        runFrame("wr_3c", 32'h823C, 16, 16);
        runFrame("rd_reg2", 32'h0200, 16, 16);
        checkOutput("rd_reg2_expect", misoBits, 16'h003C);
        runFrame("abort10", 32'h8155, 16, 10);
        checkOutput("abort10_err", frameErr, 1);
        runFrame("clear_err", 32'h8F00, 16, 16);
        runFrame("wr_oor", 32'h85FF, 16, 16);
        runFrame("rd_oor", 32'h0700, 16, 16);
        runFrame("burst24", 32'h8077FF, 24, 24);
        checkOutput("burst24_reg0", dispRegs[7:0], 8'h77);

        $display("[TB] random frames");
        for (int k = 0; k < 40; k++) randomFrame("rand", 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        csn = 1'b0;
        clkWait(HALF);
        for (int i = 0; i < 6; i++) sendBit(1'b1, i);
        mosi = 1'b1;
        sck  = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkState("midrst");
        checkOutput("midrst_miso", miso, 0);
        checkOutput("midrst_strobe", wrStrobe, 0);
        @(negedge clk);
        rst = 1'b0;
        clkWait(HALF);
        sck = 1'b0;
        for (int i = 7; i < 16; i++) sendBit(1'b1, i);
        clkWait(HALF);
        csn = 1'b1;
        clkWait(3 * HALF);
        checkState("midrst_tail");
        runFrame("post_rst", 32'h82C3, 16, 16);

        $display("[TB] frame counter wrap");
        for (int k = 0; k < 255; k++) randomFrame("wrap", 1'b1, 1'b1);
        checkOutput("cnt_wrap", frameCnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
